// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the wash programme sequencer and the cycle countdown
// timer: phase encoding, default phase durations, the duration bus width and
// the phase-order helper.
// Optional feature macro used by the sequencer: DOUBLE_WASH_EN.
// -----------------------------------------------------------------------------
package wash_pkg;

  localparam int WASH_VALUE_W = 32;
  localparam int WASH_FILL_T  = 1;
  localparam int WASH_WASH_T  = 5;
  localparam int WASH_RINSE_T = 2;
  localparam int WASH_SPIN_T  = 1;

  // Phase codes are visible on the phase output and decoded for valves/motor/pump
  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_FILL   = 3'd1,
    PH_WASH   = 3'd2,
    PH_RINSE  = 3'd3,
    PH_SPIN   = 3'd4,
    PH_WASH2  = 3'd5,
    PH_RINSE2 = 3'd6
  } phase_t;

  // Phase that follows cur once its timer completes; dbl selects the extra
  // wash/rinse pair after the first rinse.
  function automatic phase_t next_phase(input phase_t cur, input logic dbl);
    case (cur)
      PH_FILL:   next_phase = PH_WASH;
      PH_WASH:   next_phase = PH_RINSE;
      PH_RINSE:  next_phase = dbl ? PH_WASH2 : PH_SPIN;
      PH_WASH2:  next_phase = PH_RINSE2;
      PH_RINSE2: next_phase = PH_SPIN;
      PH_SPIN:   next_phase = PH_IDLE;
      default:   next_phase = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// wash_cycle_sequencer_if
// Handshake between the programme sequencer (master) and the cycle countdown
// timer (slave).
//   timer_value  : duration of the phase being loaded (master -> slave)
//   timer_load   : one-cycle restart strobe          (master -> slave)
//   timer_enable : countdown enable                  (master -> slave)
//   timer_done   : phase-complete flag               (slave -> master)
// -----------------------------------------------------------------------------
interface wash_cycle_sequencer_if #(
  parameter int VALUE_W = wash_pkg::WASH_VALUE_W
);

  logic [VALUE_W-1:0] timer_value;
  logic               timer_load;
  logic               timer_enable;
  logic               timer_done;

  modport master (
    output timer_value,
    output timer_load,
    output timer_enable,
    input  timer_done
  );

  modport slave (
    input  timer_value,
    input  timer_load,
    input  timer_enable,
    output timer_done
  );

endinterface

// File: rtl/wash_cycle_sequencer_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer_if
// Per-phase timer control: issues the cycle-0 load strobe, runs a 2-bit
// cycle-in-phase counter saturating at 2, gates the countdown enable with
// pause/door, and qualifies the timer's done flag.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   i_phase_entry    : a new phase starts at this edge
//   i_phase_exit     : programme returns to idle at this edge
//   i_busy           : sequencer is in a non-idle phase
//   i_pause          : user pause level
//   i_door_closed    : door latched level
//   i_timer_done     : raw timer done flag
//   o_load           : registered load strobe
//   o_enable         : registered countdown enable
//   o_done_q         : done flag seen at cycle 2 or later of the phase
// -----------------------------------------------------------------------------
module phase_timer_if (
  input  logic clk,
  input  logic rst,
  input  logic i_phase_entry,
  input  logic i_phase_exit,
  input  logic i_busy,
  input  logic i_pause,
  input  logic i_door_closed,
  input  logic i_timer_done,
  output logic o_load,
  output logic o_enable,
  output logic o_done_q
);

  logic       r_load;
  logic       r_enable;
  logic [1:0] r_cnt;

  // Load strobe, enable gating and saturating cycle-in-phase counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load   <= 1'b0;
      r_enable <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_phase_entry) begin
      r_load   <= 1'b1;
      r_enable <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_phase_exit || !i_busy) begin
      r_load   <= 1'b0;
      r_enable <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_load   <= 1'b0;
      r_enable <= ~i_pause & i_door_closed;
      r_cnt    <= (r_cnt == 2'd2) ? 2'd2 : (r_cnt + 2'd1);
    end
  end

  // The previous phase's done flag stays high through cycles 0 and 1, so
  // only a done seen once the counter has saturated ends the phase.
  assign o_done_q = i_busy & (r_cnt == 2'd2) & i_timer_done;
  assign o_load   = r_load;
  assign o_enable = r_enable;

endmodule

// File: rtl/wash_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// wash_cycle_sequencer
// Programme sequencer: after a coin with the door closed it steps through
// FILL -> WASH -> RINSE -> SPIN, loading each phase duration into the cycle
// countdown timer and advancing on the timer's qualified done flag.
// Optional macro DOUBLE_WASH_EN: the double_wash level captured at start
// inserts WASH2 -> RINSE2 between RINSE and SPIN.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   coin_in     : coin accepted level
//   door_closed : door latched level
//   pause       : user pause level
//   double_wash : second wash/rinse request (DOUBLE_WASH_EN builds only)
//   tmr         : timer handshake (value, load, enable out; done in)
//   phase       : current phase code
//   busy        : high in any non-idle phase
//   cycle_done  : one-cycle pulse when the programme completes
// -----------------------------------------------------------------------------
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int VALUE_W = WASH_VALUE_W,
  parameter int FILL_T  = WASH_FILL_T,
  parameter int WASH_T  = WASH_WASH_T,
  parameter int RINSE_T = WASH_RINSE_T,
  parameter int SPIN_T  = WASH_SPIN_T
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_in,
  input  logic                          door_closed,
  input  logic                          pause,
  input  logic                          double_wash,
  wash_cycle_sequencer_if.master        tmr,
  output logic [2:0]                    phase,
  output logic                          busy,
  output logic                          cycle_done
);

  phase_t             r_phase;
  logic [VALUE_W-1:0] r_value;
  logic               r_busy;
  logic               r_cycle_done;

  phase_t             w_next;
  logic               w_start;
  logic               w_advance;
  logic               w_entry;
  logic               w_finish;
  logic               w_done_q;
  logic               w_dbl;

  function automatic logic [VALUE_W-1:0] phase_dur(input phase_t ph);
    case (ph)
      PH_FILL:             phase_dur = VALUE_W'(FILL_T);
      PH_WASH, PH_WASH2:   phase_dur = VALUE_W'(WASH_T);
      PH_RINSE, PH_RINSE2: phase_dur = VALUE_W'(RINSE_T);
      PH_SPIN:             phase_dur = VALUE_W'(SPIN_T);
      default:             phase_dur = '0;
    endcase
  endfunction

`ifdef DOUBLE_WASH_EN
  logic r_dbl;

  // Capture the double-wash request once, at programme start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbl <= 1'b0;
    end else if (w_start) begin
      r_dbl <= double_wash;
    end else begin
      r_dbl <= r_dbl;
    end
  end

  assign w_dbl = r_dbl;
`else
  logic w_unused_dbl;
  assign w_unused_dbl = double_wash;
  assign w_dbl        = 1'b0;
`endif

  // Next-phase decision: start from idle, or advance on qualified done
  always_comb begin
    w_start   = 1'b0;
    w_advance = 1'b0;
    w_next    = r_phase;
    if (r_phase == PH_IDLE) begin
      if (coin_in && door_closed) begin
        w_start = 1'b1;
        w_next  = PH_FILL;
      end else begin
        w_start = 1'b0;
        w_next  = PH_IDLE;
      end
    end else begin
      if (w_done_q) begin
        w_advance = 1'b1;
        w_next    = next_phase(r_phase, w_dbl);
      end else begin
        w_advance = 1'b0;
        w_next    = r_phase;
      end
    end
  end

  assign w_entry  = w_start | (w_advance & (w_next != PH_IDLE));
  assign w_finish = w_advance & (w_next == PH_IDLE);

  // Phase FSM with registered phase, duration, busy and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase      <= PH_IDLE;
      r_value      <= '0;
      r_busy       <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_cycle_done <= w_finish;
      if (w_entry) begin
        r_phase <= w_next;
        r_value <= phase_dur(w_next);
        r_busy  <= 1'b1;
      end else if (w_finish) begin
        r_phase <= PH_IDLE;
        r_value <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_phase <= r_phase;
        r_value <= r_value;
        r_busy  <= r_busy;
      end
    end
  end

  phase_timer_if u_phase_timer (
    .clk           (clk),
    .rst           (rst),
    .i_phase_entry (w_entry),
    .i_phase_exit  (w_finish),
    .i_busy        (r_busy),
    .i_pause       (pause),
    .i_door_closed (door_closed),
    .i_timer_done  (tmr.timer_done),
    .o_load        (tmr.timer_load),
    .o_enable      (tmr.timer_enable),
    .o_done_q      (w_done_q)
  );

  assign tmr.timer_value = r_value;
  assign phase           = r_phase;
  assign busy            = r_busy;
  assign cycle_done      = r_cycle_done;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_sequencer
// Self-checking bench: a fixed vector table for the start-up, stale-done,
// pause/door and completion cases, hand-written multi-cycle sequences, then
// randomized stimulus against a phase-list reference model with a simple
// countdown-timer model driving timer_done.
// -----------------------------------------------------------------------------
module tb_wash_cycle_sequencer;

  localparam int VW = 32;
`ifdef DOUBLE_WASH_EN
  localparam bit DW_BUILD = 1'b1;
`else
  localparam bit DW_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coin_in = 1'b0, door_closed = 1'b0, pause = 1'b0, double_wash = 1'b0;
  logic [2:0] phase;
  logic busy, cycle_done;
  logic use_model = 1'b0;
  logic tb_done = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  wash_cycle_sequencer_if #(.VALUE_W(VW)) tmr ();

  wash_cycle_sequencer #(
    .VALUE_W(VW), .FILL_T(1), .WASH_T(5), .RINSE_T(2), .SPIN_T(1)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .door_closed(door_closed),
    .pause(pause), .double_wash(double_wash), .tmr(tmr.master),
    .phase(phase), .busy(busy), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  // Timer model: done after 4 enabled cycles, cleared one edge after the
  // load edge so it is stale through cycles 0 and 1 of the next phase.
  int   t_cnt;
  logic t_done, t_load_d;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_cnt <= 0; t_done <= 1'b0; t_load_d <= 1'b0;
    end else begin
      t_load_d <= tmr.timer_load;
      if (tmr.timer_load) t_cnt <= 0;
      else if (tmr.timer_enable) begin
        t_cnt <= t_cnt + 1;
        if (t_cnt >= 3) t_done <= 1'b1;
      end
      if (t_load_d) t_done <= 1'b0;
    end
  end
  assign tmr.timer_done = use_model ? t_done : tb_done;

  // Reference model: ordered list of phases, unbounded cycle count in phase
  int          m_seq[$];
  int          m_idx, m_phase, m_k;
  logic [31:0] m_value;
  logic        m_load, m_en, m_busy, m_cd;

  function automatic logic [31:0] dur(input int ph);
    case (ph)
      1: return 32'd1;
      2, 5: return 32'd5;
      3, 6: return 32'd2;
      4: return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_seq.delete(); m_idx = 0; m_phase = 0; m_k = 0;
    m_value = 32'd0; m_load = 1'b0; m_en = 1'b0; m_busy = 1'b0; m_cd = 1'b0;
  endtask

  task automatic m_enter(input int ph);
    m_phase = ph; m_k = 0; m_value = dur(ph);
    m_load = 1'b1; m_en = 1'b0; m_busy = 1'b1;
  endtask

  task automatic m_update(input logic c, input logic d, input logic p,
                          input logic dw, input logic td);
    m_cd = 1'b0;
    if (m_phase == 0) begin
      m_load = 1'b0; m_en = 1'b0;
      if (c && d) begin
        m_seq.delete();
        m_seq.push_back(1); m_seq.push_back(2); m_seq.push_back(3);
        if (dw && DW_BUILD) begin m_seq.push_back(5); m_seq.push_back(6); end
        m_seq.push_back(4);
        m_idx = 0;
        m_enter(m_seq[0]);
      end
    end else if (m_k >= 2 && td) begin
      m_idx++;
      if (m_idx == m_seq.size()) begin
        m_phase = 0; m_value = 32'd0; m_load = 1'b0; m_en = 1'b0;
        m_busy = 1'b0; m_cd = 1'b1;
      end else begin
        m_enter(m_seq[m_idx]);
      end
    end else begin
      m_k++; m_load = 1'b0; m_en = !p && d;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".phase"}, {29'd0, phase}, 32'(m_phase));
    chk({tag, ".value"}, tmr.timer_value, m_value);
    chk({tag, ".load"}, {31'd0, tmr.timer_load}, {31'd0, m_load});
    chk({tag, ".enable"}, {31'd0, tmr.timer_enable}, {31'd0, m_en});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
    chk({tag, ".cycle_done"}, {31'd0, cycle_done}, {31'd0, m_cd});
  endtask

  // One clock against the model: sample pre-edge inputs, advance, compare
  task automatic step(input string tag);
    logic c, d, p, dw, td;
    c = coin_in; d = door_closed; p = pause; dw = double_wash; td = tmr.timer_done;
    @(posedge clk);
    m_update(c, d, p, dw, td);
    #1;
    chk_model(tag);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    chk_model(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until(input int ph, input int k, input string tag);
    int n;
    n = 0;
    while (!(m_phase == ph && (ph == 0 || m_k == k)) && n < 200) begin
      step(tag);
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_err++;
      $display("FAIL %s.timeout: got no phase %0d within 200 cycles expected reached", tag, ph);
    end
  endtask

  typedef struct packed {
    logic coin, door, pse, done;
    logic [2:0] ph;
    logic [31:0] val;
    logic ld, en, bz, cd;
  } vec_t;

  function automatic vec_t mk(input logic c, d, p, td, input logic [2:0] ph,
                              input logic [31:0] v, input logic ld, en, bz, cd);
    vec_t r;
    r.coin = c; r.door = d; r.pse = p; r.done = td; r.ph = ph; r.val = v;
    r.ld = ld; r.en = en; r.bz = bz; r.cd = cd;
    return r;
  endfunction

  vec_t tbl[17];

  initial begin
    //            coin door pause done | ph val ld en bz cd
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 32'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset state
    m_reset();
    #1;
    chk_model("reset");
    @(negedge clk);
    rst = 1'b1;

    // Table vectors with directly driven timer_done
    use_model = 1'b0;
    for (int i = 0; i < 17; i++) begin
      coin_in = tbl[i].coin; door_closed = tbl[i].door;
      pause = tbl[i].pse; tb_done = tbl[i].done; double_wash = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.phase", i), {29'd0, phase}, {29'd0, tbl[i].ph});
      chk($sformatf("tbl%0d.value", i), tmr.timer_value, tbl[i].val);
      chk($sformatf("tbl%0d.load", i), {31'd0, tmr.timer_load}, {31'd0, tbl[i].ld});
      chk($sformatf("tbl%0d.enable", i), {31'd0, tmr.timer_enable}, {31'd0, tbl[i].en});
      chk($sformatf("tbl%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].bz});
      chk($sformatf("tbl%0d.cycle_done", i), {31'd0, cycle_done}, {31'd0, tbl[i].cd});
    end
    coin_in = 1'b0; tb_done = 1'b0;
    async_reset("rst_after_tbl");

    // Basic run with the timer model
    use_model = 1'b1;
    door_closed = 1'b1; pause = 1'b0; double_wash = 1'b1;
    coin_in = 1'b1;
    step("basic");
    coin_in = 1'b0;
    run_until(0, 0, "basic");

    // Pause for 10 cycles mid-WASH, then resume with no reload
    coin_in = 1'b1;
    step("pause");
    coin_in = 1'b0; double_wash = 1'b0;
    run_until(2, 1, "pause");
    pause = 1'b1;
    for (int i = 0; i < 10; i++) step("pause_hold");
    pause = 1'b0;
    step("pause_release");
    step("pause_resume");
    chk("pause.value_kept", tmr.timer_value, 32'd5);
    run_until(0, 0, "pause");

    // Coin with door open stays idle; door opens in RINSE; coin in SPIN
    door_closed = 1'b0; coin_in = 1'b1;
    for (int i = 0; i < 3; i++) step("door_open_idle");
    door_closed = 1'b1;
    step("door_start");
    coin_in = 1'b0;
    run_until(3, 1, "door");
    door_closed = 1'b0;
    for (int i = 0; i < 4; i++) step("door_rinse");
    door_closed = 1'b1;
    run_until(4, 1, "coin_spin");
    coin_in = 1'b1;
    step("coin_spin");
    coin_in = 1'b0;
    run_until(0, 0, "coin_spin");
    step("coin_spin_idle");

    // Reset mid-SPIN, then a fresh start from FILL
    coin_in = 1'b1;
    step("spin_rst");
    coin_in = 1'b0;
    run_until(4, 1, "spin_rst");
    async_reset("spin_rst_async");
    coin_in = 1'b1;
    step("after_rst");
    chk("after_rst.fill", {29'd0, phase}, 32'd1);
    coin_in = 1'b0;
    run_until(0, 0, "after_rst");

    // Randomized stimulus against the reference model
    for (int i = 0; i < 4000; i++) begin
      coin_in     = ($urandom_range(0, 7) == 0);
      door_closed = ($urandom_range(0, 15) != 0);
      pause       = ($urandom_range(0, 9) == 0);
      double_wash = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
      else step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
